// File: rtl/rf_wr_req_queue_if.sv
// rf_wr_req_queue_if
//   Groups the request handshake and the register-file write bus of the
//   rf_wr_req_queue write-request buffer.
//
//   Parameters: ADDR_W (address width), LANES (word lanes per write),
//               LANE_W (bits per lane); data width is LANES*LANE_W.
//
//   Request side : req_valid, req_ready, req_addr, req_mask, req_data
//   Write side   : wen, word_wen, wr_addr, wr_data (all registered in the queue)
//
//   master : producer of requests / consumer of writes
//   slave  : the queue itself
interface rf_wr_req_queue_if #(
  parameter int ADDR_W = 4,
  parameter int LANES  = 4,
  parameter int LANE_W = 2
);
  localparam int DATA_W = LANES * LANE_W;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [LANES-1:0]  req_mask;
  logic [DATA_W-1:0] req_data;

  logic              wen;
  logic [LANES-1:0]  word_wen;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output req_valid, req_addr, req_mask, req_data,
    input  req_ready, wen, word_wen, wr_addr, wr_data
  );

  modport slave (
    input  req_valid, req_addr, req_mask, req_data,
    output req_ready, wen, word_wen, wr_addr, wr_data
  );
endinterface

// File: rtl/rf_wr_req_queue.sv
// rf_wr_req_queue
//   Write-request buffer in front of the register-file write port. Requests
//   are accepted over a valid/ready handshake, held in a DEPTH-entry FIFO and
//   issued at most one per cycle as a registered write (wen/word_wen/wr_addr/
//   wr_data). A level flush request drains the queue and reports completion
//   with a one-cycle flush_done pulse.
//
//   Ports:
//     clk        clock, rising edge
//     reset_l    asynchronous active-low reset
//     bus        rf_wr_req_queue_if.slave (request handshake + write bus)
//     stall      downstream cannot take a write this cycle
//     flush      level request to drain the queue
//     flush_done one-cycle pulse when the drain completes
//     occupancy  entries currently held
//
//   Build option: WRQ_COALESCE_EN merges a request into the youngest queued
//   entry when the addresses match (and that entry is not popping this edge).
//
//   State table
//     state    | meaning
//     S_IDLE   | queue empty, accepting
//     S_ACTIVE | queue holds entries, accepting
//     S_FLUSH  | draining, no accepts; leaves when the queue is empty
module rf_wr_req_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 4,
  parameter int LANES  = 4,
  parameter int LANE_W = 2
) (
  input  logic                     clk,
  input  logic                     reset_l,
  rf_wr_req_queue_if.slave         bus,
  input  logic                     stall,
  input  logic                     flush,
  output logic                     flush_done,
  output logic [$clog2(DEPTH):0]   occupancy
);
  localparam int DATA_W = LANES * LANE_W;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_FLUSH  = 2'd2;

  logic [ADDR_W-1:0] q_addr [DEPTH];
  logic [LANES-1:0]  q_mask [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];

  logic [PTR_W-1:0]  head, tail, tail_m1;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [1:0]        state, state_nx;
  logic              alive;
  logic              accept, push_ok, pop, alloc, merge;

  logic              wen_q;
  logic [LANES-1:0]  word_wen_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  // alive keeps req_ready low while reset is asserted without using the
  // reset net as data.
  assign bus.req_ready = alive && (state != S_FLUSH) && (cnt < DEPTH_C);
  assign accept        = bus.req_valid && bus.req_ready;
  // A zero-mask request completes the handshake but creates no entry.
  assign push_ok       = accept && (bus.req_mask != '0);
  assign pop           = (cnt != '0) && !stall;
  assign tail_m1       = tail - PTR_ONE;

`ifdef WRQ_COALESCE_EN
  logic [DATA_W-1:0] lane_bits;
  logic [DATA_W-1:0] merged_data;

  // The youngest entry is the head only when cnt == 1; if it is leaving on
  // this edge the request must get its own slot instead.
  assign merge = push_ok && (cnt != '0) && (q_addr[tail_m1] == bus.req_addr)
                 && !(pop && (cnt == ONE_C));

  always_comb begin
    lane_bits = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_bits[i*LANE_W +: LANE_W] = {LANE_W{bus.req_mask[i]}};
    end
    merged_data = (bus.req_data & lane_bits) | (q_data[tail_m1] & ~lane_bits);
  end
`else
  assign merge = 1'b0;
`endif

  assign alloc = push_ok && !merge;

  always_comb begin
    cnt_nx = cnt;
    if (alloc && !pop) begin
      cnt_nx = cnt + ONE_C;
    end else if (!alloc && pop) begin
      cnt_nx = cnt - ONE_C;
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_addr[i] <= '0;
        q_mask[i] <= '0;
        q_data[i] <= '0;
      end
    end else begin
      cnt <= cnt_nx;
      if (alloc) begin
        q_addr[tail] <= bus.req_addr;
        q_mask[tail] <= bus.req_mask;
        q_data[tail] <= bus.req_data;
        tail         <= tail + PTR_ONE;
      end
`ifdef WRQ_COALESCE_EN
      if (merge) begin
        q_mask[tail_m1] <= q_mask[tail_m1] | bus.req_mask;
        q_data[tail_m1] <= merged_data;
      end
`endif
      if (pop) begin
        head <= head + PTR_ONE;
      end
    end
  end

  // Output registers: address/data hold their last value when idle.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      wen_q      <= 1'b0;
      word_wen_q <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      wen_q      <= pop;
      word_wen_q <= pop ? q_mask[head] : '0;
      if (pop) begin
        wr_addr_q <= q_addr[head];
        wr_data_q <= q_data[head];
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (flush) begin
          state_nx = S_FLUSH;
        end else if (cnt_nx != '0) begin
          state_nx = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (flush) begin
          state_nx = S_FLUSH;
        end else if (cnt_nx == '0) begin
          state_nx = S_IDLE;
        end
      end
      S_FLUSH: begin
        // Empty here means the final pop already happened on an earlier
        // edge, so no write remains to be issued.
        if (cnt == '0) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state      <= S_IDLE;
      alive      <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      state      <= state_nx;
      alive      <= 1'b1;
      flush_done <= (state == S_FLUSH) && (cnt == '0);
    end
  end

  assign bus.wen      = wen_q;
  assign bus.word_wen = word_wen_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign occupancy    = cnt;
endmodule
